// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART controller: parity modes,
// TX/RX state encodings and the parity helper used by both directions.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_REARM
    } rx_state_e;

    // Parity bit for a word of up to 9 bits; unused upper bits must be zero
    // so they do not contribute to the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// CPU-side valid/ready bus of the UART controller: TX push channel and
// RX first-word-fall-through pop channel.
interface uart_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty are distinguished without a level counter.
module uart_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              push_ok;
    logic              pop_ok;

    // Status flags and pointer advance; a push into a full FIFO is only
    // accepted when the head is popped in the same cycle.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    // Head word is visible as soon as it is written (fall-through).
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    // Storage array, no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Parametrised UART controller with TX/RX FIFOs, configurable frame format,
// programmable oversample divider and sticky receive error flags.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_fifo_ctrl_if.slave  bus,
    input  logic             uart_rx,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             rx_overrun,
    output logic             rx_frame_err,
    output logic             rx_parity_err,
    input  logic             err_clr
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int OW = $clog2(OVERSAMPLE);

    // ---------------- oversample tick ----------------
    logic [CW-1:0] div_q, div_d;
    logic          tick;

    // Free-running divider; tick marks the wrap cycle.
    always_comb begin
        tick  = (div_q == CW'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + CW'(1);
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    // ---------------- FIFOs ----------------
    logic [DATA_W-1:0] tx_head, rx_head;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_push_q, rx_push_d;

    assign tx_push      = bus.tx_valid && !tx_full;
    assign bus.tx_ready = !tx_full;
    // A finished frame only lands if space existed before this cycle.
    assign rx_push      = rx_push_q && !rx_full;
    assign rx_pop       = bus.rx_ready && !rx_empty;
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_head;

    uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_push),
        .wr_data (bus.tx_data),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (rx_push),
        .wr_data (rx_shift_q),
        .pop     (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // ---------------- transmitter ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [OW-1:0]     tx_os_q, tx_os_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_bit_end;

    // TX next-state: each non-idle state lasts OVERSAMPLE ticks per bit; the
    // FIFO is popped either from IDLE or straight out of the last stop bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_bit_end = tick && (tx_os_q == OW'(OVERSAMPLE - 1));
        if (tx_state_q != TX_IDLE && tick) begin
            tx_os_d = tx_bit_end ? '0 : tx_os_q + OW'(1);
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_par_d   = parity_bit(9'(tx_head), PARITY);
                    tx_os_d    = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 4'(DATA_W - 1)) begin
                        tx_bit_d = '0;
                        if (PARITY != PARITY_NONE) tx_state_d = TX_PARITY;
                        else                       tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_head;
                            tx_par_d   = parity_bit(9'(tx_head), PARITY);
                            tx_state_d = TX_START;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    // TX state register; the pin itself is registered to stay glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign uart_tx = tx_line_q;
    assign tx_busy = (tx_state_q != TX_IDLE) || !tx_empty;

    // ---------------- receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [OW-1:0] rx_os_q, rx_os_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic          rx_fall, rx_mid;
    logic          set_par, set_frame, set_ovr;
    logic          ovr_q, ovr_d, frame_q, frame_d, par_q, par_d;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // RX next-state: phase count restarts at the falling edge so samples
    // land at bit centres; a low stop bit drops the word and re-arms.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_d  = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        rx_fall    = rx_s3_q && !rx_s2_q;
        rx_mid     = tick && (rx_os_q == OW'(OVERSAMPLE - 1));
        if ((rx_state_q == RX_DATA || rx_state_q == RX_PARITY ||
             rx_state_q == RX_STOP) && tick) begin
            rx_os_d = rx_mid ? '0 : rx_os_q + OW'(1);
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_os_d    = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_os_q == OW'(OVERSAMPLE / 2 - 1)) begin
                        rx_os_d  = '0;
                        rx_bit_d = '0;
                        if (rx_s2_q) rx_state_d = RX_IDLE;
                        else         rx_state_d = RX_DATA;
                    end else begin
                        rx_os_d = rx_os_q + OW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_bit_q == 4'(DATA_W - 1)) begin
                        rx_bit_d = '0;
                        if (PARITY != PARITY_NONE) rx_state_d = RX_PARITY;
                        else                       rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_mid) begin
                    set_par    = (rx_s2_q != parity_bit(9'(rx_shift_q), PARITY));
                    rx_bit_d   = '0;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    if (!rx_s2_q) begin
                        set_frame  = 1'b1;
                        rx_state_d = RX_REARM;
                    end else if (rx_bit_q == 4'(STOP_BITS - 1)) begin
                        rx_push_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_REARM: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_push_q  <= rx_push_d;
        end
    end

    // Sticky flags: a set event wins over a simultaneous clear.
    always_comb begin
        set_ovr = rx_push_q && rx_full;
        ovr_d   = set_ovr   ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
        frame_d = set_frame ? 1'b1 : (err_clr ? 1'b0 : frame_q);
        par_d   = set_par   ? 1'b1 : (err_clr ? 1'b0 : par_q);
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q   <= 1'b0;
            frame_q <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            ovr_q   <= ovr_d;
            frame_q <= frame_d;
            par_q   <= par_d;
        end
    end

    assign rx_overrun    = ovr_q;
    assign rx_frame_err  = frame_q;
    assign rx_parity_err = par_q;

endmodule
